// File: rtl/alu_pipe_if.sv
// Request/result bus for alu_pipe: valid/ready request beat in, registered result beat and flags out.
interface alu_pipe_if #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [SHW-1:0]   d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             S;
    logic             Z;
    logic             C;
    logic             V;
    logic             HLT;

    modport master (
        output in_valid, opcode, in1, in2, d, out_ready,
        input  in_ready, out_valid, out, S, Z, C, V, HLT
    );

    modport slave (
        input  in_valid, opcode, in1, in2, d, out_ready,
        output in_ready, out_valid, out, S, Z, C, V, HLT
    );
endinterface

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags and a sticky halt opcode.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier on opcode 12.
//
// state | meaning
// IDLE  | accepting requests when the result slot is free
// MUL   | shift-add multiply in progress, requests blocked
// HALT  | halt opcode seen, requests blocked until reset
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input logic       clk,
    input logic       rst_n,
    alu_pipe_if.slave bus
);
    localparam int M = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, MUL, HALT} state_t;

    state_t           state, state_nxt;
    logic             accept;
    logic             is_mul_op;
    logic             mul_done;
    logic             flag_en;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] alu_out;
    logic             c_f, v_f;
    logic [WIDTH:0]   sum, dif, shl, shr;
    logic signed [WIDTH:0] sra;
    logic [WIDTH-1:0] rot;
    logic [SHW:0]     rot_back;
    logic             ld;
    logic [WIDTH-1:0] ld_out;
    logic [3:0]       ld_flags;

    assign bus.in_ready = rst_n && (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        sum      = {1'b0, bus.in1} + {1'b0, bus.in2};
        dif      = {1'b0, bus.in1} - {1'b0, bus.in2};
        // extra bit beyond the operand catches the last bit shifted out
        shl      = {1'b0, bus.in2} << bus.d;
        shr      = {bus.in2, 1'b0} >> bus.d;
        sra      = $signed({bus.in2, 1'b0}) >>> bus.d;
        rot_back = (SHW+1)'(WIDTH) - {1'b0, bus.d};
        rot      = (bus.in2 << bus.d) | (bus.in2 >> rot_back);
        res      = '0;
        c_f      = 1'b0;
        v_f      = 1'b0;
        flag_en  = 1'b1;
        case (bus.opcode)
            4'd0: begin
                res = sum[M:0];
                c_f = sum[WIDTH];
                v_f = (bus.in1[M] == bus.in2[M]) && (sum[M] != bus.in1[M]);
            end
            4'd1, 4'd5: begin
                res = dif[M:0];
                c_f = dif[WIDTH];
                v_f = (bus.in1[M] != bus.in2[M]) && (dif[M] != bus.in1[M]);
            end
            4'd2:    res = bus.in1 & bus.in2;
            4'd3:    res = bus.in1 | bus.in2;
            4'd4:    res = bus.in1 ^ bus.in2;
            4'd6:    res = bus.in2;
            4'd8: begin
                res = shl[M:0];
                c_f = shl[WIDTH];
            end
            4'd9:    res = rot;
            4'd10: begin
                res = shr[WIDTH:1];
                c_f = shr[0];
            end
            4'd11: begin
                res = sra[WIDTH:1];
                c_f = sra[0];
            end
            default: flag_en = 1'b0;
        endcase
        alu_out = (bus.opcode == 4'd5) ? '0 : res;
    end

`ifdef ALU_PIPE_MUL_EN
    logic [2*WIDTH-1:0] acc, mcand, acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       cnt;
    logic               mul_step;

    assign is_mul_op = (bus.opcode == 4'd12);
    assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
    // the final step waits if the previous beat is still unconsumed
    assign mul_done  = (state == MUL) && (cnt == 1) && (!bus.out_valid || bus.out_ready);
    assign mul_step  = (state == MUL) && ((cnt != 1) || mul_done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept && is_mul_op) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.in1};
            mplier <= bus.in2;
            cnt    <= (SHW+1)'(WIDTH);
        end else if (mul_step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

    always_comb begin
        ld       = (accept && !is_mul_op) || mul_done;
        ld_out   = alu_out;
        ld_flags = {flag_en & res[M], flag_en & (res == '0), c_f, v_f};
        if (mul_done) begin
            ld_out   = acc_nxt[M:0];
            ld_flags = {acc_nxt[M], acc_nxt[M:0] == '0, |acc_nxt[2*WIDTH-1:WIDTH], 1'b0};
        end
    end
`else
    assign is_mul_op = 1'b0;
    assign mul_done  = 1'b0;

    always_comb begin
        ld       = accept;
        ld_out   = alu_out;
        ld_flags = {flag_en & res[M], flag_en & (res == '0), c_f, v_f};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && bus.opcode == 4'd15) state_nxt = HALT;
                else if (accept && is_mul_op)      state_nxt = MUL;
            end
            MUL:     if (mul_done) state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out       <= '0;
            bus.S         <= 1'b0;
            bus.Z         <= 1'b0;
            bus.C         <= 1'b0;
            bus.V         <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.HLT       <= 1'b0;
        end else begin
            if (ld) begin
                bus.out                          <= ld_out;
                {bus.S, bus.Z, bus.C, bus.V}     <= ld_flags;
                bus.out_valid                    <= 1'b1;
            end else if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (accept && bus.opcode == 4'd15) bus.HLT <= 1'b1;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed and random checks of alu_pipe against an expected-result queue.
module tb_alu_pipe;
    typedef struct packed {
        logic [15:0] o;
        logic        s;
        logic        z;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    bit   beat_checked = 1'b0;
    exp_t expq[$];

    alu_pipe_if #(.WIDTH(16), .SHW(4)) bus ();

    alu_pipe #(.WIDTH(16), .SHW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                   input logic [3:0] dd);
        longint ua = a;
        longint ub = b;
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint r = 0;
        logic [15:0] t = b;
        logic c = 1'b0;
        logic v = 1'b0;
        bit   fl = 1'b1;
        exp_t e;
        case (op)
            4'd0: begin r = ua + ub; c = (r > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            4'd1, 4'd5: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 32767) || (sa - sb < -32768); end
            4'd2: r = longint'(a & b);
            4'd3: r = longint'(a | b);
            4'd4: r = longint'(a ^ b);
            4'd6: r = ub;
            4'd8: begin
                for (int i = 0; i < int'(dd); i++) begin c = t[15]; t = {t[14:0], 1'b0}; end
                r = longint'(t);
            end
            4'd9: begin
                for (int i = 0; i < int'(dd); i++) t = {t[14:0], t[15]};
                r = longint'(t);
            end
            4'd10: begin
                for (int i = 0; i < int'(dd); i++) begin c = t[0]; t = {1'b0, t[15:1]}; end
                r = longint'(t);
            end
            4'd11: begin
                for (int i = 0; i < int'(dd); i++) begin c = t[0]; t = {t[15], t[15:1]}; end
                r = longint'(t);
            end
`ifdef ALU_PIPE_MUL_EN
            4'd12: begin r = ua * ub; c = ((r >> 16) != 0); end
`endif
            default: fl = 1'b0;
        endcase
        e.o = (op == 4'd5 || !fl) ? 16'h0 : r[15:0];
        e.s = fl & r[15];
        e.z = fl & (r[15:0] == 16'h0);
        e.c = fl & c;
        e.v = fl & v;
        return e;
    endfunction

    // one clock; a newly valid result beat is compared with the oldest expectation
    task automatic tick();
        bit   hs;
        exp_t e;
        hs = bus.out_valid && bus.out_ready;
        @(posedge clk);
        #1;
        if (hs) beat_checked = 1'b0;
        if (bus.out_valid && !beat_checked) begin
            beat_checked = 1'b1;
            chk(32'(expq.size() != 0), 32'd1, "beat_expected");
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk(32'(bus.out), 32'(e.o), "beat_out");
                chk(32'({bus.S, bus.Z, bus.C, bus.V}), 32'({e.s, e.z, e.c, e.v}), "beat_flags");
            end
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] dd, input exp_t e, input bit push, input bit lat1);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.in1      = a;
        bus.in2      = b;
        bus.d        = dd;
        #1;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(32'(bus.in_ready), 32'd1, "accept");
        if (push) expq.push_back(e);
        tick();
        bus.in_valid = 1'b0;
        if (lat1) chk(32'(bus.out_valid), 32'd1, "latency1");
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        chk(32'({bus.out_valid, bus.HLT, bus.in_ready}), 32'd0, "reset_async");
        @(negedge clk);
        rst_n = 1'b1;
        beat_checked = 1'b0;
        @(posedge clk);
        #1;
        chk(32'({bus.in_ready, bus.HLT}), 32'b10, "reset_release");
    endtask

    initial begin
        logic [3:0] ops [12];
        logic [3:0] op;
        logic [15:0] a, b;
        logic [3:0] dd;
        logic [15:0] held;
        int n;
        bit seen;

        ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14};
        bus.in_valid  = 1'b0;
        bus.opcode    = 4'd0;
        bus.in1       = 16'h0;
        bus.in2       = 16'h0;
        bus.d         = 4'd0;
        bus.out_ready = 1'b1;

        #12;
        chk(32'(bus.out), 32'd0, "rst_out");
        chk(32'({bus.S, bus.Z, bus.C, bus.V}), 32'd0, "rst_flags");
        chk(32'({bus.out_valid, bus.HLT, bus.in_ready}), 32'd0, "rst_ctrl");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(32'(bus.in_ready), 32'd1, "ready_after_rst");

        // directed vectors, back to back
        send(4'd0,  16'h7FFF, 16'h0001, 4'd0, '{o:16'h8000, s:1'b1, z:1'b0, c:1'b0, v:1'b1}, 1, 1);
        send(4'd1,  16'h0000, 16'h0001, 4'd0, '{o:16'hFFFF, s:1'b1, z:1'b0, c:1'b1, v:1'b0}, 1, 1);
        send(4'd5,  16'h1234, 16'h1234, 4'd0, '{o:16'h0000, s:1'b0, z:1'b1, c:1'b0, v:1'b0}, 1, 1);
        send(4'd11, 16'h0000, 16'h8000, 4'd3, '{o:16'hF000, s:1'b1, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd10, 16'h0000, 16'h0009, 4'd1, '{o:16'h0004, s:1'b0, z:1'b0, c:1'b1, v:1'b0}, 1, 1);
        send(4'd8,  16'h0000, 16'h8001, 4'd1, '{o:16'h0002, s:1'b0, z:1'b0, c:1'b1, v:1'b0}, 1, 1);
        send(4'd9,  16'h0000, 16'h8001, 4'd4, '{o:16'h0018, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd8,  16'h0000, 16'h8001, 4'd0, '{o:16'h8001, s:1'b1, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd6,  16'h1111, 16'hABCD, 4'd0, '{o:16'hABCD, s:1'b1, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd7,  16'hFFFF, 16'hFFFF, 4'd5, '{o:16'h0000, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd13, 16'h8000, 16'h8000, 4'd1, '{o:16'h0000, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        send(4'd0,  16'h8000, 16'h8000, 4'd0, '{o:16'h0000, s:1'b0, z:1'b1, c:1'b1, v:1'b1}, 1, 1);

        // random mix against the reference model
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 11)];
            a  = 16'($urandom);
            b  = 16'($urandom);
            dd = 4'($urandom);
            send(op, a, b, dd, model(op, a, b, dd), 1, 1);
        end
        tick();
        chk(32'(expq.size()), 32'd0, "drain");

        // back-pressure: result held three cycles, then released with a same-cycle accept
        bus.out_ready = 1'b0;
        send(4'd0, 16'h0001, 16'h0002, 4'd0, '{o:16'h0003, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        held = bus.out;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk(32'({bus.out_valid, bus.in_ready}), 32'b10, "bp_ctrl");
            chk(32'(bus.out), 32'h0003, "bp_out");
            chk(32'({bus.S, bus.Z, bus.C, bus.V}), 32'd0, "bp_flags");
        end
        chk(32'(held), 32'h0003, "bp_held");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'd4;
        bus.in1       = 16'h00FF;
        bus.in2       = 16'h0F0F;
        #1;
        chk(32'(bus.in_ready), 32'd1, "bp_release_ready");
        send(4'd4, 16'h00FF, 16'h0F0F, 4'd0, '{o:16'h0FF0, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        tick();

`ifdef ALU_PIPE_MUL_EN
        send(4'd12, 16'h0100, 16'h0100, 4'd0, '{o:16'h0000, s:1'b0, z:1'b1, c:1'b1, v:1'b0}, 1, 0);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk(32'(n), 32'd17, "mul_latency");
        send(4'd12, 16'h1234, 16'h0056, 4'd0, model(4'd12, 16'h1234, 16'h0056, 4'd0), 1, 0);
        n = 0;
        while (expq.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        chk(32'(expq.size()), 32'd0, "mul_done");
        send(4'd12, 16'h00FF, 16'h00FF, 4'd0, '{o:16'h0, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 0, 0);
        repeat (7) tick();
        pulse_reset();
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk(32'(seen), 32'd0, "mul_abort_no_beat");
`else
        send(4'd12, 16'h0100, 16'h0100, 4'd0, '{o:16'h0000, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        tick();
`endif

        // halt: one beat, then requests ignored until reset
        send(4'd15, 16'h1234, 16'h5678, 4'd0, '{o:16'h0000, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        chk(32'(bus.HLT), 32'd1, "hlt_set");
        bus.in_valid = 1'b1;
        bus.opcode   = 4'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk(32'(bus.in_ready), 32'd0, "halt_ready");
        end
        chk(32'({bus.HLT, bus.out_valid}), 32'b10, "halt_state");
        chk(32'(expq.size()), 32'd0, "halt_queue");
        bus.in_valid = 1'b0;
        pulse_reset();
        send(4'd3, 16'h00F0, 16'h0F00, 4'd0, '{o:16'h0FF0, s:1'b0, z:1'b0, c:1'b0, v:1'b0}, 1, 1);
        tick();
        chk(32'(expq.size()), 32'd0, "final_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set operand/result width in bits (minimum 8, power of two).
REQ-002 Parameter SHW, default 4, SHALL set shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  rising-edge clock; one clock domain, all state on clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  request beat valid.
REQ-006 in_ready  output  1  block accepts request this cycle.
REQ-007 opcode  input  4  operation select.
REQ-008 in1  input  WIDTH  operand Rd.
REQ-009 in2  input  WIDTH  operand Rs.
REQ-010 d  input  SHW  shift/rotate amount.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 out  output  WIDTH  registered result.
REQ-014 S, Z, C, V  output  1 each  registered sign, zero, carry, overflow flags.
REQ-015 HLT  output  1  sticky halt indication.

Function
REQ-016 Request SHALL be accepted when in_valid && in_ready; in_ready SHALL be 1 only in state IDLE with (!out_valid || out_ready).
REQ-017 States SHALL be IDLE, MUL, HALT; reset enters IDLE.
REQ-018 Single-cycle opcodes SHALL load out/flags and set out_valid on the edge after acceptance (latency 1); back-to-back throughput 1/cycle with out_ready=1.
REQ-019 out/flags SHALL hold stable while out_valid && !out_ready; out_valid SHALL clear on handshake unless a new result loads the same edge.
REQ-020 Opcodes: 0 add, 1 sub (in1-in2), 2 and, 3 or, 4 xor, 5 cmp (out=0, flags of sub), 6 mov (out=in2), 8 SLL in2<<d, 9 rotate-left in2 by d, 10 SRL, 11 SRA (sign-filling), 12 MUL (see Configuration); 7, 13, 14 SHALL give out=0, S=Z=C=V=0.
REQ-021 S SHALL equal result bit WIDTH-1; Z SHALL equal (result==0); for cmp, result means the subtraction result.
REQ-022 Add: C = unsigned carry-out, V = signed overflow; sub/cmp: C = borrow (in1<in2 unsigned), V = signed overflow.
REQ-023 Logic, mov, rotate: C=0, V=0.
REQ-024 SLL: C = last bit shifted out (in2[WIDTH-d]); SRL/SRA: C = in2[d-1]; d=0 SHALL give result=in2, C=0; V=0 for all shifts.
REQ-025 Opcode 15 SHALL produce one result beat out=0, flags 0, set HLT=1 and enter HALT; HALT SHALL hold in_ready=0 until reset; pending result beat SHALL still complete handshake.
REQ-026 Arithmetic SHALL be WIDTH-bit modulo; no sign extension of out.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, out=0, S=Z=C=V=0, out_valid=0, HLT=0, in_ready=0 while low.
REQ-028 Reset during MUL or HALT SHALL abort the operation with no result beat; in_ready SHALL rise the first cycle after rst_n deasserts.

Configuration
REQ-029 Macro ALU_PIPE_MUL_EN defined: opcode 12 SHALL enter state MUL, run a shift-add multiply for exactly WIDTH cycles with in_ready=0, then load out=low WIDTH bits of in1*in2 (unsigned), C=(high WIDTH bits != 0), V=0, S/Z per REQ-021; total latency WIDTH+1 cycles from acceptance.
REQ-030 Macro ALU_PIPE_MUL_EN undefined: no multiplier logic SHALL exist; opcode 12 SHALL behave as opcode 7 with latency 1.

Verification
REQ-031 add 0x7FFF+0x0001 -> out=0x8000, S=1, Z=0, C=0, V=1 one cycle after acceptance.
REQ-032 sub 0x0000-0x0001 -> out=0xFFFF, S=1, C=1, V=0; cmp 0x1234,0x1234 -> out=0, Z=1, C=0.
REQ-033 SRA 0x8000 d=3 -> 0xF000, C=0; SRL 0x0009 d=1 -> 0x0004, C=1; SLL 0x8001 d=1 -> 0x0002, C=1; rotate 0x8001 d=4 -> 0x0018.
REQ-034 out_ready held 0 for 3 cycles after result -> out/flags unchanged, in_ready=0; out_ready=1 -> handshake, next request accepted same cycle.
REQ-035 With ALU_PIPE_MUL_EN: MUL 0x0100*0x0100 -> out=0x0000, Z=1, C=1 exactly 17 cycles after acceptance; rst_n pulse at cycle 8 -> no beat; without macro -> out=0, flags 0 after 1 cycle.
REQ-036 opcode 15 -> one beat, HLT=1, in_ready=0 for 20 cycles despite in_valid=1; rst_n pulse -> HLT=0, in_ready=1.
